// File: rtl/led_fade_pkg.sv
// Shared constants for the RGB fade scheduler: register map, CTRL/STATUS bits, FSM codes.
// No logic and no latency; these are constants and one pure helper function.
// Backpressure: not applicable.
package led_fade_pkg;

  // Bus page that selects this peripheral (iomem_addr[31:24]).
  localparam logic [7:0] IOMEM_PAGE = 8'h03;

  // Register offsets relative to the block's base offset.
  localparam logic [7:0] REG_CTRL_OFS   = 8'h00;
  localparam logic [7:0] REG_TARGET_OFS = 8'h04;
  localparam logic [7:0] REG_STATUS_OFS = 8'h08;

  // CTRL bit positions.
  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_SNAP_BIT  = 1;
  localparam int CTRL_IRQ_BIT   = 2;
  localparam int CTRL_PER_LSB   = 16;

  // STATUS bit positions.
  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_DONE_BIT  = 1;
  localparam int STAT_CUR_LSB   = 8;

  // FSM encoding, kept as plain constants so older tools can consume it.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RAMP = 1'b1;

  // One colour as seen on the bus: {B,G,R}, red in the low byte.
  typedef struct packed {
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } rgb_t;

  // Move one LSB from cur toward tgt; unchanged when already equal.
  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
    logic [7:0] res;
    res = cur;
    if (cur < tgt) begin
      res = cur + 8'd1;
    end else if (cur > tgt) begin
      res = cur - 8'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/led_fade_step.sv
// One colour channel: current duty register that steps one LSB toward its target or snap-loads.
// Latency: the new value appears one clock after step_i/snap_i are sampled.
// Backpressure: none; step_i and snap_i are single-cycle strobes from the scheduler.
module led_fade_step
  import led_fade_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       step_i,      // advance one LSB toward tgt_i this cycle
  input  logic       snap_i,      // load snap_val_i directly (wins over step_i)
  input  logic [7:0] snap_val_i,
  input  logic [7:0] tgt_i,       // target in force for this cycle's step
  output logic [7:0] cur_o,       // current duty
  output logic       eq_o         // the stepped value would land on tgt_i
);

  logic [7:0] cur_q;
  logic [7:0] cur_d;
  logic [7:0] stepped;

  // Next duty: snap load has priority, otherwise a step toward the target.
  always_comb begin
    stepped = step_toward(cur_q, tgt_i);
    cur_d   = cur_q;
    if (snap_i) begin
      cur_d = snap_val_i;
    end else if (step_i) begin
      cur_d = stepped;
    end
  end

  // Duty register with synchronous reset to fully off.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cur_q <= 8'h00;
    end else begin
      cur_q <= cur_d;
    end
  end

  assign cur_o = cur_q;
  assign eq_o  = (stepped == tgt_i);

endmodule

// File: rtl/led_fade_ctrl.sv
// Memory-mapped RGB fade scheduler: ramps three pwm duties toward a target at one LSB per step.
// Latency: bus ack and read data one clock after a selected request; first step P clocks after a TARGET ack.
// Backpressure: none; every selected request is acknowledged on the next edge, unselected ones never.
module led_fade_ctrl
  import led_fade_pkg::*;
#(
  parameter logic [7:0] BASE_OFFSET = 8'h10,
  parameter int         PERIOD_W    = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic [7:0]  duty_r,
  output logic [7:0]  duty_g,
  output logic [7:0]  duty_b,
  output logic        irq_done
);

  localparam logic [7:0] ADDR_CTRL   = BASE_OFFSET + REG_CTRL_OFS;
  localparam logic [7:0] ADDR_TARGET = BASE_OFFSET + REG_TARGET_OFS;
  localparam logic [7:0] ADDR_STATUS = BASE_OFFSET + REG_STATUS_OFS;

  // Architectural registers.
  logic                en_q, en_d;
  logic                snap_q, snap_d;
  logic                irq_en_q, irq_en_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] presc_q, presc_d;
  rgb_t                tgt_q, tgt_d;
  logic [0:0]          state_q, state_d;
  logic                done_q, done_d;
  logic                ready_q, ready_d;
  logic [31:0]         rdata_q, rdata_d;

  // Decode and control strobes.
  logic                page_ok;
  logic                hit_ctrl, hit_tgt, hit_stat;
  logic                sel, wr;
  logic                done_w1c;
  logic                snap_load;
  logic                step;
  logic                done_set;
  logic                wrap;
  logic [PERIOD_W-1:0] last_cnt;
  logic [15:0]         per16;
  logic [31:0]         rd_val;
  rgb_t                cur;
  logic [2:0]          ch_eq;

  // Address bits between the page and the register window are not decoded.
  logic                unused_addr;
  assign unused_addr = ^iomem_addr[23:8];

  // Request decode: only a fresh (not-yet-acked) request on our page and offsets is taken.
  always_comb begin
    page_ok  = (iomem_addr[31:24] == IOMEM_PAGE);
    hit_ctrl = (iomem_addr[7:0] == ADDR_CTRL);
    hit_tgt  = (iomem_addr[7:0] == ADDR_TARGET);
    hit_stat = (iomem_addr[7:0] == ADDR_STATUS);
    sel      = iomem_valid & ~ready_q & page_ok & (hit_ctrl | hit_tgt | hit_stat);
    wr       = sel & (|iomem_wstrb);
  end

  // Read mux over pre-edge register contents.
  always_comb begin
    rd_val = 32'h0;
    if (hit_ctrl) begin
      rd_val = {per16_of(period_q), 13'h0, irq_en_q, snap_q, en_q};
    end else if (hit_tgt) begin
      rd_val = {8'h00, tgt_q};
    end else if (hit_stat) begin
      rd_val = {cur, 6'h00, done_q, (state_q == ST_RAMP)};
    end
  end

  function automatic logic [15:0] per16_of(input logic [PERIOD_W-1:0] p);
    return 16'(p);
  endfunction

  // Register writes, honouring byte strobes; STATUS only carries the done W1C.
  always_comb begin
    en_d     = en_q;
    snap_d   = snap_q;
    irq_en_d = irq_en_q;
    per16    = per16_of(period_q);
    tgt_d    = tgt_q;
    done_w1c = 1'b0;
    if (wr && hit_ctrl) begin
      if (iomem_wstrb[0]) begin
        en_d     = iomem_wdata[CTRL_EN_BIT];
        snap_d   = iomem_wdata[CTRL_SNAP_BIT];
        irq_en_d = iomem_wdata[CTRL_IRQ_BIT];
      end
      if (iomem_wstrb[2]) per16[7:0]  = iomem_wdata[CTRL_PER_LSB +: 8];
      if (iomem_wstrb[3]) per16[15:8] = iomem_wdata[CTRL_PER_LSB+8 +: 8];
    end
    if (wr && hit_tgt) begin
      if (iomem_wstrb[0]) tgt_d.r = iomem_wdata[7:0];
      if (iomem_wstrb[1]) tgt_d.g = iomem_wdata[15:8];
      if (iomem_wstrb[2]) tgt_d.b = iomem_wdata[23:16];
    end
    if (wr && hit_stat && iomem_wstrb[0] && iomem_wdata[STAT_DONE_BIT]) begin
      done_w1c = 1'b1;
    end
    period_d = per16[PERIOD_W-1:0];
  end

  // A step fires when the prescaler reaches period-1 (period 0 behaves as 1). Using >=
  // lets a shortened period take effect on the very next cycle.
  always_comb begin
    last_cnt = (period_q == '0) ? '0 : (period_q - PERIOD_W'(1));
    wrap     = (presc_q >= last_cnt);
  end

  // Scheduler FSM. A snap-mode TARGET write overrides any ramp in progress; the IDLE
  // exit looks at post-write enable/target so the first step lands exactly P clocks
  // after the ack. A step always uses the target that was in force before this edge.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    step      = 1'b0;
    done_set  = 1'b0;
    snap_load = wr & hit_tgt & snap_q;
    if (snap_load) begin
      state_d  = ST_IDLE;
      presc_d  = '0;
      done_set = en_d;
    end else if (state_q == ST_IDLE) begin
      presc_d = '0;
      if (en_d && (cur != tgt_d)) begin
        state_d = ST_RAMP;
      end
    end else if (!en_d) begin
      state_d = ST_IDLE;
      presc_d = '0;
    end else if (wrap) begin
      step    = 1'b1;
      presc_d = '0;
      if (&ch_eq) begin
        done_set = 1'b1;
        state_d  = ST_IDLE;
      end
    end else begin
      presc_d = presc_q + PERIOD_W'(1);
    end
  end

  // Sticky done flag: a set in the same cycle as a clear wins.
  always_comb begin
    done_d = done_q;
    if (done_w1c) done_d = 1'b0;
    if (done_set) done_d = 1'b1;
  end

  // Single-cycle ack; read data is zero whenever ready is low so buses can be OR-ed.
  always_comb begin
    ready_d = sel;
    rdata_d = sel ? rd_val : 32'h0;
  end

  // All control and bus state, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      en_q     <= 1'b0;
      snap_q   <= 1'b0;
      irq_en_q <= 1'b0;
      period_q <= PERIOD_W'(1);
      presc_q  <= '0;
      tgt_q    <= '0;
      state_q  <= ST_IDLE;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      en_q     <= en_d;
      snap_q   <= snap_d;
      irq_en_q <= irq_en_d;
      period_q <= period_d;
      presc_q  <= presc_d;
      tgt_q    <= tgt_d;
      state_q  <= state_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
    end
  end

  led_fade_step u_step_r (
    .clk        (clk),
    .resetn     (resetn),
    .step_i     (step),
    .snap_i     (snap_load),
    .snap_val_i (tgt_d.r),
    .tgt_i      (tgt_q.r),
    .cur_o      (cur.r),
    .eq_o       (ch_eq[0])
  );

  led_fade_step u_step_g (
    .clk        (clk),
    .resetn     (resetn),
    .step_i     (step),
    .snap_i     (snap_load),
    .snap_val_i (tgt_d.g),
    .tgt_i      (tgt_q.g),
    .cur_o      (cur.g),
    .eq_o       (ch_eq[1])
  );

  led_fade_step u_step_b (
    .clk        (clk),
    .resetn     (resetn),
    .step_i     (step),
    .snap_i     (snap_load),
    .snap_val_i (tgt_d.b),
    .tgt_i      (tgt_q.b),
    .cur_o      (cur.b),
    .eq_o       (ch_eq[2])
  );

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign duty_r      = cur.r;
  assign duty_g      = cur.g;
  assign duty_b      = cur.b;
  assign irq_done    = done_q & irq_en_q;

endmodule

// File: tb/tb_led_fade_ctrl.sv
// Self-checking bench for led_fade_ctrl: directed scenarios plus random bus traffic.
// Outputs are compared every cycle against a transaction-level colour-ramp model.
// The bus is driven one request at a time; the model decides which requests are acked.
module tb_led_fade_ctrl;

  localparam logic [31:0] A_CTRL   = 32'h0300_0010;
  localparam logic [31:0] A_TARGET = 32'h0300_0014;
  localparam logic [31:0] A_STATUS = 32'h0300_0018;

  logic        clk = 1'b0;
  logic        resetn;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic [7:0]  duty_r, duty_g, duty_b;
  logic        irq_done;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state, in register-map terms.
  logic [7:0]  m_cur [3];
  logic [7:0]  m_tgt [3];
  logic        m_en, m_snap, m_irq, m_ramp, m_done, m_rdy;
  logic [15:0] m_per;
  int          m_cnt;
  logic [31:0] m_rdata;

  always #5 clk = ~clk;

  led_fade_ctrl dut (
    .clk         (clk),
    .resetn      (resetn),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .duty_r      (duty_r),
    .duty_g      (duty_g),
    .duty_b      (duty_b),
    .irq_done    (irq_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, expected %h", tag, $time, got, exp);
    end
  endtask

  // Advance the model across one clock edge given the bus inputs presented to it.
  task automatic model_edge(input logic rn, input logic v, input logic [3:0] s,
                            input logic [31:0] a, input logic [31:0] d);
    logic        sel, wr, clr, snap_load, set_done, all_eq, differ;
    logic [31:0] rd;
    logic        n_en, n_snap, n_irq;
    logic [15:0] n_per;
    logic [7:0]  n_tgt [3];
    int          eff;
    if (!rn) begin
      for (int i = 0; i < 3; i++) begin m_cur[i] = 8'h00; m_tgt[i] = 8'h00; end
      m_en = 0; m_snap = 0; m_irq = 0; m_ramp = 0; m_done = 0; m_rdy = 0;
      m_per = 16'd1; m_cnt = 0; m_rdata = 32'h0;
      return;
    end
    sel = v && !m_rdy && (a[31:24] == 8'h03) &&
          (a[7:0] == 8'h10 || a[7:0] == 8'h14 || a[7:0] == 8'h18);
    rd = 32'h0;
    if (a[7:0] == 8'h10) rd = {m_per, 13'd0, m_irq, m_snap, m_en};
    else if (a[7:0] == 8'h14) rd = {8'h00, m_tgt[2], m_tgt[1], m_tgt[0]};
    else if (a[7:0] == 8'h18) rd = {m_cur[2], m_cur[1], m_cur[0], 6'd0, m_done, m_ramp};
    wr = sel && (s != 4'h0);
    n_en = m_en; n_snap = m_snap; n_irq = m_irq; n_per = m_per;
    for (int i = 0; i < 3; i++) n_tgt[i] = m_tgt[i];
    if (wr && a[7:0] == 8'h10) begin
      if (s[0]) begin n_en = d[0]; n_snap = d[1]; n_irq = d[2]; end
      if (s[2]) n_per[7:0]  = d[23:16];
      if (s[3]) n_per[15:8] = d[31:24];
    end
    if (wr && a[7:0] == 8'h14)
      for (int i = 0; i < 3; i++) if (s[i]) n_tgt[i] = d[8*i +: 8];
    clr       = wr && (a[7:0] == 8'h18) && s[0] && d[1];
    snap_load = wr && (a[7:0] == 8'h14) && m_snap;
    set_done  = 0;
    eff       = (m_per == 16'd0) ? 1 : int'(m_per);
    differ    = 0;
    for (int i = 0; i < 3; i++) if (m_cur[i] != n_tgt[i]) differ = 1;
    if (snap_load) begin
      for (int i = 0; i < 3; i++) m_cur[i] = n_tgt[i];
      set_done = n_en; m_ramp = 0; m_cnt = 0;
    end else if (!m_ramp) begin
      m_cnt = 0;
      if (n_en && differ) m_ramp = 1;
    end else if (!n_en) begin
      m_ramp = 0; m_cnt = 0;
    end else if (m_cnt >= eff - 1) begin
      all_eq = 1;
      for (int i = 0; i < 3; i++) begin
        if (m_cur[i] < m_tgt[i]) m_cur[i] = m_cur[i] + 8'd1;
        else if (m_cur[i] > m_tgt[i]) m_cur[i] = m_cur[i] - 8'd1;
        if (m_cur[i] != m_tgt[i]) all_eq = 0;
      end
      m_cnt = 0;
      if (all_eq) begin set_done = 1; m_ramp = 0; end
    end else begin
      m_cnt++;
    end
    m_done = (m_done && !clr) || set_done;
    m_en = n_en; m_snap = n_snap; m_irq = n_irq; m_per = n_per;
    for (int i = 0; i < 3; i++) m_tgt[i] = n_tgt[i];
    m_rdy   = sel;
    m_rdata = sel ? rd : 32'h0;
  endtask

  task automatic check_all();
    chk("duty",  {8'h00, duty_b, duty_g, duty_r}, {8'h00, m_cur[2], m_cur[1], m_cur[0]});
    chk("ready", {31'd0, iomem_ready}, {31'd0, m_rdy});
    chk("rdata", iomem_rdata, m_rdata);
    chk("irq",   {31'd0, irq_done}, {31'd0, m_done & m_irq});
  endtask

  // Present inputs at the falling edge, step the model, check after the next falling edge.
  task automatic tick(input logic v, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
    iomem_valid = v; iomem_wstrb = s; iomem_addr = a; iomem_wdata = d;
    model_edge(resetn, v, s, a, d);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    tick(1'b1, 4'hF, a, d);
    idle(1);
  endtask

  task automatic bus_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    tick(1'b1, 4'h0, a, 32'h0);
    chk(tag, iomem_rdata, exp);
    idle(1);
  endtask

  initial begin
    int k;
    resetn = 1'b0;
    iomem_valid = 1'b0; iomem_wstrb = 4'h0; iomem_addr = 32'h0; iomem_wdata = 32'h0;
    @(negedge clk);
    idle(3);
    resetn = 1'b1;
    idle(2);

    // Reset state.
    bus_rd("rst_status", A_STATUS, 32'h0000_0000);
    bus_rd("rst_ctrl",   A_CTRL,   32'h0001_0000);
    tick(1'b1, 4'h0, 32'h0300_0020, 32'h0);
    chk("unmapped_rdy",   {31'd0, iomem_ready}, 32'd0);
    chk("unmapped_rdata", iomem_rdata, 32'h0);
    idle(1);

    // Full red ramp at period 4: 255 steps, last one 1020 clocks after the ack.
    bus_wr(A_CTRL, 32'h0004_0005);
    tick(1'b1, 4'hF, A_TARGET, 32'h0000_00FF);
    k = 0;
    for (int i = 1; i <= 1100; i++) begin
      idle(1);
      if (duty_r == 8'hFF) begin k = i; break; end
    end
    chk("ramp_len", k, 1020);
    idle(3);
    chk("ramp_irq", {31'd0, irq_done}, 32'd1);
    bus_rd("ramp_status", A_STATUS, 32'h0000_FF02);

    // Green rising to 0x80, retargeted to 0x20 once it reaches 0x40.
    bus_wr(A_TARGET, 32'h0000_80FF);
    k = 0;
    for (int i = 0; i < 600; i++) begin
      if (duty_g == 8'h40) begin k = 1; break; end
      idle(1);
    end
    chk("rev_reach40", k, 1);
    tick(1'b1, 4'hF, A_TARGET, 32'h0000_20FF);
    for (int i = 0; i < 10 && duty_g == 8'h40; i++) idle(1);
    chk("rev_first", {24'd0, duty_g}, 32'h3F);
    for (int i = 0; i < 300 && duty_g != 8'h20; i++) idle(1);
    idle(6);
    chk("rev_end", {24'd0, duty_g}, 32'h20);

    // Clear done, then snap.
    bus_wr(A_STATUS, 32'h0000_0002);
    chk("w1c_irq", {31'd0, irq_done}, 32'd0);
    bus_wr(A_CTRL, 32'h0004_0007);
    tick(1'b1, 4'hF, A_TARGET, 32'h0012_3456);
    chk("snap_duty", {8'h00, duty_b, duty_g, duty_r}, 32'h0012_3456);
    chk("snap_irq", {31'd0, irq_done}, 32'd1);
    idle(1);
    bus_rd("snap_status", A_STATUS, 32'h1234_5602);

    // Disable mid-ramp, then resume.
    bus_wr(A_CTRL, 32'h0004_0005);
    bus_wr(A_STATUS, 32'h0000_0002);
    bus_wr(A_TARGET, 32'h0000_0000);
    idle(40);
    bus_wr(A_CTRL, 32'h0004_0004);
    idle(20);
    tick(1'b1, 4'h0, A_STATUS, 32'h0);
    chk("freeze_flags", {30'd0, iomem_rdata[1:0]}, 32'd0);
    idle(1);
    bus_wr(A_CTRL, 32'h0001_0005);
    for (int i = 0; i < 200 && {duty_b, duty_g, duty_r} != 24'h0; i++) idle(1);
    idle(2);
    chk("resume_end", {8'h00, duty_b, duty_g, duty_r}, 32'h0);

    // W1C landing on the final step: the set wins.
    bus_wr(A_CTRL, 32'h0004_0005);
    bus_wr(A_STATUS, 32'h0000_0002);
    tick(1'b1, 4'hF, A_TARGET, 32'h0000_0001);
    idle(3);
    tick(1'b1, 4'hF, A_STATUS, 32'h0000_0002);
    idle(1);
    bus_rd("w1c_race", A_STATUS, 32'h0000_0102);
    bus_wr(A_STATUS, 32'h0000_0002);
    bus_rd("w1c_later", A_STATUS, 32'h0000_0100);
    chk("w1c_later_irq", {31'd0, irq_done}, 32'd0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      int op;
      logic [31:0] d;
      logic [3:0]  s;
      op = $urandom_range(0, 9);
      s  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'hF;
      case (op)
        0, 1, 2: idle($urandom_range(1, 20));
        3: begin
          d = {16'($urandom_range(0, 5)), 13'd0, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 4) != 0)};
          tick(1'b1, s, A_CTRL, d);
        end
        4, 5: tick(1'b1, s, A_TARGET, $urandom);
        6: tick(1'b1, s, A_STATUS, $urandom);
        7: begin
          case ($urandom_range(0, 4))
            0: d = A_CTRL;
            1: d = A_TARGET;
            2: d = A_STATUS;
            3: d = 32'h0300_0020;
            default: d = 32'h0200_0010;
          endcase
          tick(1'b1, 4'h0, d, 32'h0);
        end
        8: begin
          if ($urandom_range(0, 3) == 0) begin
            resetn = 1'b0;
            idle($urandom_range(1, 2));
            resetn = 1'b1;
          end else begin
            idle(3);
          end
        end
        default: begin
          tick(1'b1, s, A_TARGET, $urandom);
          tick(1'b1, s, A_TARGET, $urandom);
        end
      endcase
      idle(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/led_fade_ctrl.md
Name: led_fade_ctrl

Overview:
Memory-mapped RGB fade scheduler on the PicoSoC iomem bus. It sequences the 8-bit duty inputs of the three RGB pwm instances. Firmware writes a target colour and a step period; the block ramps each channel by one LSB per step toward the target, then raises a sticky done flag and an optional interrupt.

Parameters:
BASE_OFFSET, 8'h10, iomem_addr[7:0] base of the 3-word register window; decode also requires iomem_addr[31:24]==8'h03
PERIOD_W, 16, width of the step-period field and prescaler

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
iomem_valid  in  1  bus request
iomem_ready  out  1  one-cycle acknowledge, only for selected addresses
iomem_wstrb  in  4  byte write strobes; 0 = read
iomem_addr  in  32  byte address
iomem_wdata  in  32  write data
iomem_rdata  out  32  read data; zero when iomem_ready=0 (OR-combinable)
duty_r  out  8  current red duty to pwm
duty_g  out  8  current green duty to pwm
duty_b  out  8  current blue duty to pwm
irq_done  out  1  level: done_flag & irq_en

Behaviour:
- Reset (resetn=0 at clk edge): duty_r/g/b=0, targets=0, enable=0, snap=0, irq_en=0, period=1, prescaler=0, done_flag=0, state=IDLE, iomem_ready=0, iomem_rdata=0, irq_done=0. Reset mid-ramp aborts immediately to these values.
- Register map (offset from BASE_OFFSET):
  +0 CTRL RW: [0] enable, [1] snap, [2] irq_en, [31:16] period (clocks per step; 0 treated as 1).
  +4 TARGET RW: [7:0] R, [15:8] G, [23:16] B; [31:24] read 0.
  +8 STATUS: [0] busy (RO), [1] done_flag (write 1 clears), [31:8] current {B,G,R}.
- Bus: select = valid & !ready & addr[31:24]==03 & addr[7:0] in {+0,+4,+8}. Selected request: ready=1 and rdata valid on the next edge, ready=0 the edge after. Writes honour wstrb per byte. Unselected: ready stays 0, rdata=0.
- FSM: IDLE, RAMP.
  IDLE -> RAMP when enable=1 and current != target. Prescaler is cleared on entry.
  RAMP: prescaler counts 0..period-1. At count==period-1, each channel with current!=target moves +/-1 toward it and the prescaler wraps to 0. If after that step all channels equal target: done_flag<=1, state<=IDLE.
  RAMP -> IDLE with prescaler cleared when enable is written 0. Duties freeze and done_flag is not set.
- Timing: after a TARGET write acknowledged at edge E0 (enable=1, period P), the first duty change appears at edge E0+P. A full 0->FF ramp completes at E0+255*P.
- TARGET write during RAMP: prescaler continues (no restart). New target applies from the next step. A channel already past the new target reverses direction.
- TARGET write with snap=1: duties load the written bytes on the same edge as the ack. done_flag<=1 if enable=1. State -> IDLE.
- Step edge coincides with a TARGET write: the step uses the old target; the new target is registered.
- Step sets done_flag in the same cycle as a W1C: set wins.
- Period write during RAMP takes effect at the next prescaler wrap. If prescaler>=new period-1, it wraps on the next cycle.
- busy = (state==RAMP).

Decomposition:
- Shared package led_fade_pkg: register offsets (CTRL/TARGET/STATUS), CTRL bit positions, state encoding, IOMEM_PAGE=8'h03.
- One sub-module led_fade_step: per-channel 8-bit current register with step-toward-target, snap load and equality output. Instantiated three times.
- Bus decode, prescaler and FSM stay in led_fade_ctrl.

Test Plan:
- Reset then read STATUS/CTRL -> STATUS=0x0000_0000, CTRL=0x0001_0000, duties 0, irq_done=0; read at addr 0x0300_0020 -> no ready, rdata=0.
- CTRL=0x0004_0005 (period 4, enable, irq_en), TARGET=0x0000_00FF -> duty_r increments every 4 clocks, reaches 0xFF at E0+1020; busy drops; done_flag=1; irq_done=1.
- Mid-ramp at duty_g=0x40 (rising), TARGET G=0x20 -> duty_g reverses to 0x3F on the next step without prescaler restart, ends at 0x20.
- CTRL snap=1, write TARGET=0x0012_3456 -> duties {B,G,R}={12,34,56} on the ack edge; done_flag=1; busy never asserts.
- Enable=0 written mid-ramp -> duties freeze, busy=0, done_flag stays 0; re-enable -> ramp resumes from frozen values.
- Write STATUS=0x2 on the same cycle as the final step -> done_flag remains 1; a later STATUS=0x2 write clears it and irq_done=0.
